// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: FSM state encoding and occupancy width.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  function automatic logic [OCC_W-1:0] state_occ(input pipe_state_t s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload + write-enable holding register; clear_wena vacates the slot
// without disturbing the payload bits.
module pipe_slot #(
  parameter int DATA_W = 256,
  parameter int WENA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear_wena,
  input  logic [DATA_W-1:0] d_data,
  input  logic [WENA_W-1:0] d_wena,
  output logic [DATA_W-1:0] q_data,
  output logic [WENA_W-1:0] q_wena
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_data <= '0;
      q_wena <= '0;
    end else if (load) begin
      q_data <= d_data;
      q_wena <= d_wena;
    end else if (clear_wena) begin
      q_wena <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: MAIN drives the outputs, SKID absorbs one beat on a stall
// so in_ready depends only on registered state.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | no beat held, outputs idle
//   ST_ONE   | MAIN holds the beat being presented
//   ST_TWO   | MAIN presented, SKID holds the next beat
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int WENA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WENA_W-1:0] in_wena,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [WENA_W-1:0] out_wena,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_state_t state, state_nxt;

  logic              in_fire, out_fire;
  logic              main_load, main_clr, main_sel_skid;
  logic              skid_load, skid_clr;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [WENA_W-1:0] main_wena, skid_wena, main_d_wena;

  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state_occ(state);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_nxt = ST_TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
            main_clr  = 1'b1;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_nxt     = ST_ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // SKID always refills MAIN ahead of any newer beat, preserving FIFO order
  assign main_d_data = main_sel_skid ? skid_data : in_data;
  assign main_d_wena = main_sel_skid ? skid_wena : in_wena;

  pipe_slot #(.DATA_W(DATA_W), .WENA_W(WENA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .load       (main_load),
    .clear_wena (main_clr),
    .d_data     (main_d_data),
    .d_wena     (main_d_wena),
    .q_data     (main_data),
    .q_wena     (main_wena)
  );

  pipe_slot #(.DATA_W(DATA_W), .WENA_W(WENA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear_wena (skid_clr),
    .d_data     (in_data),
    .d_wena     (in_wena),
    .q_data     (skid_data),
    .q_wena     (skid_wena)
  );

  assign out_data = main_data;
  assign out_wena = main_wena & {WENA_W{out_valid}};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: the driver queues expected beats, a negedge
// monitor pops and compares every transfer the stage makes.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DATA_W = 256;
  localparam int WENA_W = 4;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [WENA_W-1:0] in_wena, out_wena;
  logic [OCC_W-1:0]  occupancy;

  logic [DATA_W+WENA_W-1:0] sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int beat_cnt  = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .WENA_W(WENA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_wena   (in_wena),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_wena  (out_wena),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic [WENA_W-1:0] w,
                            input logic ordy, input logic exp_acc);
    in_valid  = 1'b1;
    in_data   = d;
    in_wena   = w;
    out_ready = ordy;
    chk("in_ready", {255'd0, in_ready}, {255'd0, exp_acc});
    if (exp_acc) sb.push_back({d, w});
    tick();
    in_valid = 1'b0;
  endtask

  // A transfer happens at the next posedge when these hold mid-cycle
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_beat: got data %0h wena %0h, required no beat", out_data, out_wena);
        end else begin
          logic [DATA_W+WENA_W-1:0] e;
          e = sb.pop_front();
          beat_cnt++;
          chk("beat_data", out_data, e[DATA_W+WENA_W-1:WENA_W]);
          chk("beat_wena", {252'd0, out_wena}, {252'd0, e[WENA_W-1:0]});
        end
      end else if (out_valid === 1'b0) begin
        chk("idle_wena", {252'd0, out_wena}, 256'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_wena = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("rst_out_data",  out_data, 256'd0);
    chk("rst_out_wena",  {252'd0, out_wena}, 256'd0);
    chk("rst_occ",       {254'd0, occupancy}, 256'd0);
    chk("rst_in_ready",  {255'd0, in_ready}, 256'd1);

    // single beat, one-cycle latency
    drive_beat(256'hDEADBEEF, 4'b0001, 1'b1, 1'b1);
    chk("single_valid", {255'd0, out_valid}, 256'd1);
    chk("single_data",  out_data, 256'hDEADBEEF);
    chk("single_occ",   {254'd0, occupancy}, 256'd1);
    tick();
    chk("single_occ_after", {254'd0, occupancy}, 256'd0);

    // back-to-back streaming
    for (int i = 0; i < 16; i++) drive_beat(DATA_W'(i), WENA_W'(i), 1'b1, 1'b1);
    tick();
    chk("stream_occ_end", {254'd0, occupancy}, 256'd0);

    // stall fills SKID, then drains in order
    drive_beat(256'hA, 4'b0010, 1'b0, 1'b1);
    drive_beat(256'hB, 4'b0011, 1'b0, 1'b1);
    chk("stall_occ", {254'd0, occupancy}, 256'd2);
    drive_beat(256'hE, 4'b0101, 1'b0, 1'b0);
    chk("stall_occ_hold", {254'd0, occupancy}, 256'd2);
    out_ready = 1'b1;
    tick();
    chk("drain1_in_ready", {255'd0, in_ready}, 256'd1);
    chk("drain1_occ", {254'd0, occupancy}, 256'd1);
    tick();
    chk("drain2_occ", {254'd0, occupancy}, 256'd0);

    // flush while full, with a beat offered and out_ready high
    drive_beat(256'h1, 4'b1111, 1'b0, 1'b1);
    drive_beat(256'h2, 4'b1111, 1'b0, 1'b1);
    chk("full_occ", {254'd0, occupancy}, 256'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = 256'hC; in_wena = 4'b1111; out_ready = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_out_valid", {255'd0, out_valid}, 256'd0);
    chk("flush_out_wena",  {252'd0, out_wena}, 256'd0);
    chk("flush_occ",       {254'd0, occupancy}, 256'd0);
    chk("flush_in_ready",  {255'd0, in_ready}, 256'd1);

    // flush against a simultaneous drain in ONE
    drive_beat(256'h5, 4'b0100, 1'b0, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0;
    chk("flush_drain_wena", {252'd0, out_wena}, 256'd0);
    chk("flush_drain_occ",  {254'd0, occupancy}, 256'd0);
    drive_beat(256'h6, 4'b1000, 1'b1, 1'b1);
    tick();

    // reset overrides flush and handshake in TWO
    drive_beat(256'h7, 4'b1111, 1'b0, 1'b1);
    drive_beat(256'h8, 4'b1111, 1'b0, 1'b1);
    chk("pre_rst_occ", {254'd0, occupancy}, 256'd2);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 256'h9; in_wena = 4'b1111;
    sb.delete();
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rst2_out_valid", {255'd0, out_valid}, 256'd0);
    chk("rst2_out_data",  out_data, 256'd0);
    chk("rst2_out_wena",  {252'd0, out_wena}, 256'd0);
    chk("rst2_occ",       {254'd0, occupancy}, 256'd0);
    chk("rst2_in_ready",  {255'd0, in_ready}, 256'd1);

    out_ready = 1'b1;
    repeat (3) tick();
    chk("sb_empty",  DATA_W'(sb.size()), 256'd0);
    chk("beats_out", DATA_W'(beat_cnt), 256'd20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
